// File: rtl/spike_window_counter.sv
// Spike-count readout: accumulates per-PE spike counts over a programmed window,
// scans for the most active PE, then streams the count histogram over valid/ready.
`timescale 1ns/1ps
module spike_window_counter #(
  parameter int NUM_PE = 8,
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 8,
  parameter int IDX_W  = $clog2(NUM_PE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIN_W-1:0]  window_len,
  input  logic [NUM_PE-1:0] in_spikes,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_last,
  output logic [IDX_W-1:0]  out_winner
);

  localparam int SCAN_W = IDX_W + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PE - 1);
  localparam logic [SCAN_W-1:0] SCAN_END = SCAN_W'(NUM_PE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_ARGMAX,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   len_q, len_d;
  logic [WIN_W-1:0]   t_q, t_d;
  logic [CNT_W-1:0]   cnt_q [NUM_PE];
  logic [CNT_W-1:0]   cnt_d [NUM_PE];
  logic [SCAN_W-1:0]  scan_q, scan_d;
  logic [CNT_W-1:0]   best_q, best_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [IDX_W-1:0]   beat_q, beat_d;
  logic [IDX_W-1:0]   scan_idx;

  // Counters stick at all-ones instead of wrapping so a hot PE never looks quiet.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    if (inc && (c != {CNT_W{1'b1}}))
      return c + 1'b1;
    return c;
  endfunction

  assign scan_idx = scan_q[IDX_W-1:0];

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    t_d        = t_q;
    cnt_d      = cnt_q;
    scan_d     = scan_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    winner_d   = winner_q;
    beat_d     = beat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = window_len;
          t_d        = '0;
          scan_d     = '0;
          best_d     = '0;
          best_idx_d = '0;
          beat_d     = '0;
          for (int i = 0; i < NUM_PE; i++) cnt_d[i] = '0;
          state_d = (window_len == '0) ? S_ARGMAX : S_COUNT;
        end
      end
      S_COUNT: begin
        for (int i = 0; i < NUM_PE; i++) cnt_d[i] = sat_inc(cnt_q[i], in_spikes[i]);
        t_d = t_q + 1'b1;
        if (t_q == len_q - 1'b1) state_d = S_ARGMAX;
      end
      S_ARGMAX: begin
        // One PE per cycle; the extra final cycle latches the winner.
        if (scan_q == SCAN_END) begin
          winner_d = best_idx_q;
          beat_d   = '0;
          state_d  = S_DRAIN;
        end else begin
          if (cnt_q[scan_idx] > best_q) begin
            best_d     = cnt_q[scan_idx];
            best_idx_d = scan_idx;
          end
          scan_d = scan_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (beat_q == LAST_IDX) begin
            beat_d  = '0;
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      t_q        <= '0;
      scan_q     <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      winner_q   <= '0;
      beat_q     <= '0;
      for (int i = 0; i < NUM_PE; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      t_q        <= t_d;
      scan_q     <= scan_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      winner_q   <= winner_d;
      beat_q     <= beat_d;
      for (int i = 0; i < NUM_PE; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Outputs decode only registered state, so nothing depends on out_ready combinationally.
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (state_q == S_DRAIN);
  assign out_index  = out_valid ? beat_q : '0;
  assign out_count  = out_valid ? cnt_q[beat_q] : '0;
  assign out_last   = out_valid && (beat_q == LAST_IDX);
  assign out_winner = winner_q;

endmodule
